// File: rtl/ram_cpu_share_arb.sv
// Arbitrates a single dual-port RAM between a streaming engine and a slow CPU port.
// The engine has priority, and a starvation counter eventually forces the CPU in.
module ram_cpu_share_arb #(
    parameter int ADDRBIT = 5,
    parameter int WIDTH   = 32,
    parameter int RDLAT   = 2,
    parameter int STARVE  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic               eng_re,
    input  logic               eng_we,
    input  logic [ADDRBIT-1:0] eng_ra,
    input  logic [ADDRBIT-1:0] eng_wa,
    input  logic [WIDTH-1:0]   eng_wrd,
    output logic [WIDTH-1:0]   eng_rdd,
    output logic               eng_rvld,
    output logic               eng_stall,
    input  logic               upen,
    input  logic               upws,
    input  logic               uprs,
    input  logic [ADDRBIT-1:0] upa,
    input  logic [WIDTH-1:0]   updi,
    output logic [WIDTH-1:0]   updo,
    output logic               uprdy,
    output logic               memwe,
    output logic               memre,
    output logic [ADDRBIT-1:0] memwa,
    output logic [ADDRBIT-1:0] memra,
    output logic [WIDTH-1:0]   memwrd,
    input  logic [WIDTH-1:0]   memrdd
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PEND    = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;
    localparam logic [7:0] STARVE_MAX = 8'(STARVE);

    logic               live;
    logic               engw;
    logic               engr;
    logic [1:0]         state_q, state_d;
    logic [7:0]         starve_q, starve_d;
    logic               cpuWr_q, cpuWr_d;
    logic [ADDRBIT-1:0] cpuA_q, cpuA_d;
    logic [WIDTH-1:0]   cpuD_q, cpuD_d;
    logic [WIDTH-1:0]   updo_q, updo_d;

    logic               pend;
    logic               portBusy;
    logic               forced;
    logic               grant;
    logic               cpuWrGo;
    logic               cpuRdGo;
    logic               engWrGo;
    logic               engRdGo;
    logic               rdIssue;
    logic [ADDRBIT-1:0] rdAddr;

    // Read pipeline: one slot per cycle of latency, each carrying its own forwarding capture.
    logic [RDLAT-1:0]   pValid_q, pValid_d;
    logic [RDLAT-1:0]   pCpu_q, pCpu_d;
    logic [RDLAT-1:0]   pFwd_q, pFwd_d;
    logic [ADDRBIT-1:0] pAddr_q [RDLAT];
    logic [ADDRBIT-1:0] pAddr_d [RDLAT];
    logic [WIDTH-1:0]   pData_q [RDLAT];
    logic [WIDTH-1:0]   pData_d [RDLAT];

    logic               retValid;
    logic               retCpu;
    logic [WIDTH-1:0]   retData;

    assign live = ~rst;
    assign engw = eng_we & active & live;
    assign engr = eng_re & active & live;

    assign pend     = live & upen & (state_q == PEND);
    assign portBusy = cpuWr_q ? engw : engr;
    assign forced   = (starve_q == STARVE_MAX);
    assign grant    = pend & (~portBusy | forced);
    assign cpuWrGo  = grant & cpuWr_q;
    assign cpuRdGo  = grant & ~cpuWr_q;
    assign engWrGo  = engw & ~cpuWrGo;
    assign engRdGo  = engr & ~cpuRdGo;

    assign eng_stall = grant & portBusy;

    assign memwe  = engWrGo | cpuWrGo;
    assign memwa  = cpuWrGo ? cpuA_q : eng_wa;
    assign memwrd = cpuWrGo ? cpuD_q : eng_wrd;

    assign rdIssue = engRdGo | cpuRdGo;
    assign rdAddr  = cpuRdGo ? cpuA_q : eng_ra;
    assign memra   = rdAddr;
    // A same-address write this cycle makes the RAM read pointless; forwarding supplies the data.
    assign memre   = rdIssue & ~(memwe & (memwa == rdAddr));

    assign retValid = pValid_q[RDLAT-1] & live;
    assign retCpu   = pCpu_q[RDLAT-1];
    assign retData  = (memwe && (memwa == pAddr_q[RDLAT-1])) ? memwrd :
                      pFwd_q[RDLAT-1] ? pData_q[RDLAT-1] : memrdd;

    assign eng_rdd  = retValid ? retData : '0;
    assign eng_rvld = retValid & ~retCpu;
    assign uprdy    = live & upen & (state_q == DONE);
    assign updo     = (live & upen) ? updo_q : '0;

    always_comb begin
        pValid_d   = '0;
        pCpu_d     = '0;
        pFwd_d     = '0;
        pValid_d[0] = rdIssue;
        pCpu_d[0]   = cpuRdGo;
        pAddr_d[0]  = rdAddr;
        pData_d[0]  = '0;
        for (int k = 1; k < RDLAT; k++) begin
            pValid_d[k] = pValid_q[k-1];
            pCpu_d[k]   = pCpu_q[k-1];
            pFwd_d[k]   = pFwd_q[k-1];
            pAddr_d[k]  = pAddr_q[k-1];
            pData_d[k]  = pData_q[k-1];
        end
        // Youngest same-address write wins; an abandoned CPU read is dropped so it cannot return later.
        for (int k = 0; k < RDLAT; k++) begin
            if (memwe && (memwa == pAddr_d[k])) begin
                pFwd_d[k]  = 1'b1;
                pData_d[k] = memwrd;
            end
            if (!upen && pCpu_d[k]) begin
                pValid_d[k] = 1'b0;
                pCpu_d[k]   = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = '0;
        cpuWr_d  = cpuWr_q;
        cpuA_d   = cpuA_q;
        cpuD_d   = cpuD_q;
        updo_d   = updo_q;
        case (state_q)
            IDLE: begin
                if (upen && (upws || uprs)) begin
                    cpuWr_d = upws;
                    cpuA_d  = upa;
                    cpuD_d  = updi;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!upen) begin
                    state_d = IDLE;
                end else if (grant) begin
                    state_d = cpuWr_q ? DONE : WAIT_RD;
                end else begin
                    starve_d = forced ? starve_q : starve_q + 8'd1;
                end
            end
            WAIT_RD: begin
                if (!upen) begin
                    state_d = IDLE;
                end else if (retValid && retCpu) begin
                    updo_d  = retData;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            cpuWr_q  <= 1'b0;
            cpuA_q   <= '0;
            cpuD_q   <= '0;
            updo_q   <= '0;
            pValid_q <= '0;
            pCpu_q   <= '0;
            pFwd_q   <= '0;
            for (int k = 0; k < RDLAT; k++) begin
                pAddr_q[k] <= '0;
                pData_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            cpuWr_q  <= cpuWr_d;
            cpuA_q   <= cpuA_d;
            cpuD_q   <= cpuD_d;
            updo_q   <= updo_d;
            pValid_q <= pValid_d;
            pCpu_q   <= pCpu_d;
            pFwd_q   <= pFwd_d;
            for (int k = 0; k < RDLAT; k++) begin
                pAddr_q[k] <= pAddr_d[k];
                pData_q[k] <= pData_d[k];
            end
        end
    end

endmodule

// File: tb/tb_ram_cpu_share_arb.sv
// Bench for ram_cpu_share_arb: a behavioural RAM plus a shadow-memory reference model,
// a randomized engine-only phase, then directed CPU/engine arbitration scenarios.
module tb_ram_cpu_share_arb;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        active, eng_re, eng_we;
    logic [4:0]  eng_ra, eng_wa;
    logic [31:0] eng_wrd, eng_rdd;
    logic        eng_rvld, eng_stall;
    logic        upen, upws, uprs;
    logic [4:0]  upa;
    logic [31:0] updi, updo;
    logic        uprdy;
    logic        memwe, memre;
    logic [4:0]  memwa, memra;
    logic [31:0] memwrd, memrdd;

    logic [31:0] ram [32];
    logic [31:0] rdPipe [LAT];
    logic [31:0] shadow [32];

    typedef struct {
        int         due;
        logic [4:0] addr;
    } rdExp_t;
    rdExp_t expQ[$];

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    ram_cpu_share_arb dut (
        .clk(clk), .rst(rst), .active(active),
        .eng_re(eng_re), .eng_we(eng_we), .eng_ra(eng_ra), .eng_wa(eng_wa),
        .eng_wrd(eng_wrd), .eng_rdd(eng_rdd), .eng_rvld(eng_rvld), .eng_stall(eng_stall),
        .upen(upen), .upws(upws), .uprs(uprs), .upa(upa), .updi(updi),
        .updo(updo), .uprdy(uprdy),
        .memwe(memwe), .memre(memre), .memwa(memwa), .memra(memra),
        .memwrd(memwrd), .memrdd(memrdd)
    );

    function automatic logic [31:0] initVal(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    // RAM reads return the pre-write contents of the issue cycle, LAT cycles later.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) ram[i] <= initVal(i);
            for (int i = 0; i < LAT; i++) rdPipe[i] <= '0;
        end else begin
            for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
            if (memre) rdPipe[0] <= ram[memra];
            if (memwe) ram[memwa] <= memwrd;
        end
    end
    assign memrdd = rdPipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic r, act, ere, ewe, input logic [4:0] ra, wa,
                                 input logic [31:0] wd, input logic en, ws, rs,
                                 input logic [4:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst = r; active = act; eng_re = ere; eng_we = ewe; eng_ra = ra; eng_wa = wa;
        eng_wrd = wd; upen = en; upws = ws; uprs = rs; upa = a; updi = d;
        @(negedge clk);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_uprdy"}, 32'(uprdy), 32'd0);
        checkOutput({tag, "_rvld"}, 32'(eng_rvld), 32'd0);
        checkOutput({tag, "_stall"}, 32'(eng_stall), 32'd0);
        checkOutput({tag, "_memwe"}, 32'(memwe), 32'd0);
        checkOutput({tag, "_memre"}, 32'(memre), 32'd0);
        checkOutput({tag, "_rdd"}, eng_rdd, 32'd0);
        checkOutput({tag, "_updo"}, updo, 32'd0);
    endtask

    initial begin
        logic        actR, reR, weR, engrR, engwR, expV;
        logic [4:0]  raR, waR;
        logic [31:0] wdR;

        rst = 1'b1; active = 0; eng_re = 0; eng_we = 0; eng_ra = 0; eng_wa = 0; eng_wrd = 0;
        upen = 0; upws = 0; uprs = 0; upa = 0; updi = 0;
        for (int i = 0; i < 32; i++) shadow[i] = initVal(i);

        applyStimulus(1, 1, 1, 1, 5'd1, 5'd1, 32'h1234, 1, 0, 0, 0, 0);
        checkQuiet("in_rst");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkQuiet("post_rst");

        // Random engine traffic against the shadow memory: expected read data is the
        // memory state after all writes up to and including the return cycle.
        for (int c = 0; c < 304; c++) begin
            actR = ($urandom_range(0, 9) != 0) && (c < 300);
            reR  = 1'($urandom_range(0, 1));
            weR  = 1'($urandom_range(0, 1));
            raR  = 5'($urandom_range(0, 7));
            waR  = 5'($urandom_range(0, 7));
            wdR  = $urandom;
            applyStimulus(0, actR, reR, weR, raR, waR, wdR, 0, 0, 0, 0, 0);
            engrR = actR & reR;
            engwR = actR & weR;
            if (engwR) shadow[waR] = wdR;
            checkOutput("rnd_memwe", 32'(memwe), 32'(engwR));
            checkOutput("rnd_memre", 32'(memre), 32'(engrR && !(engwR && waR == raR)));
            checkOutput("rnd_stall", 32'(eng_stall), 32'd0);
            if (engwR) begin
                checkOutput("rnd_memwa", 32'(memwa), 32'(waR));
                checkOutput("rnd_memwrd", memwrd, wdR);
            end
            expV = (expQ.size() > 0) && (expQ[0].due == c);
            checkOutput("rnd_rvld", 32'(eng_rvld), 32'(expV));
            if (expV) begin
                checkOutput("rnd_rdd", eng_rdd, shadow[expQ[0].addr]);
                void'(expQ.pop_front());
            end
            if (engrR) expQ.push_back('{c + LAT, raR});
        end
        checkOutput("rnd_drained", 32'(expQ.size()), 32'd0);

        // CPU write, engine idle
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'd3, 32'hA5A5A5A5);
        checkOutput("w_strobe_memwe", 32'(memwe), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 32'h0);
        checkOutput("w_memwe", 32'(memwe), 32'd1);
        checkOutput("w_memwa", 32'(memwa), 32'd3);
        checkOutput("w_memwrd", memwrd, 32'hA5A5A5A5);
        checkOutput("w_uprdy_early", 32'(uprdy), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("w_uprdy", 32'(uprdy), 32'd1);
        checkOutput("w_memwe_after", 32'(memwe), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("w_uprdy_once", 32'(uprdy), 32'd0);

        // Starvation: engine writes address 7 every cycle while a CPU write waits
        applyStimulus(0, 1, 0, 1, 0, 5'd7, 32'h77, 1, 1, 0, 5'd5, 32'hC0FFEE00);
        checkOutput("st_strobe_stall", 32'(eng_stall), 32'd0);
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(0, 1, 0, 1, 0, 5'd7, 32'h77, 1, 0, 0, 0, 0);
            checkOutput("st_wait_stall", 32'(eng_stall), 32'd0);
            checkOutput("st_wait_memwa", 32'(memwa), 32'd7);
            checkOutput("st_wait_uprdy", 32'(uprdy), 32'd0);
        end
        applyStimulus(0, 1, 0, 1, 0, 5'd7, 32'h77, 1, 0, 0, 0, 0);
        checkOutput("st_force_stall", 32'(eng_stall), 32'd1);
        checkOutput("st_force_memwe", 32'(memwe), 32'd1);
        checkOutput("st_force_memwa", 32'(memwa), 32'd5);
        checkOutput("st_force_memwrd", memwrd, 32'hC0FFEE00);
        applyStimulus(0, 1, 0, 1, 0, 5'd7, 32'h77, 1, 0, 0, 0, 0);
        checkOutput("st_after_stall", 32'(eng_stall), 32'd0);
        checkOutput("st_uprdy", 32'(uprdy), 32'd1);
        checkOutput("st_after_memwa", 32'(memwa), 32'd7);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("st_uprdy_once", 32'(uprdy), 32'd0);

        // Forwarding from the two writes after the read
        applyStimulus(0, 1, 1, 0, 5'd4, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 5'd4, 32'h11, 1, 0, 0, 0, 0);
        checkOutput("fw_rvld_early", 32'(eng_rvld), 32'd0);
        applyStimulus(0, 1, 0, 1, 0, 5'd4, 32'h22, 1, 0, 0, 0, 0);
        checkOutput("fw_rvld", 32'(eng_rvld), 32'd1);
        checkOutput("fw_rdd", eng_rdd, 32'h22);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("fw_rvld_once", 32'(eng_rvld), 32'd0);

        // Same-cycle read and write to address 9
        applyStimulus(0, 1, 1, 1, 5'd9, 5'd9, 32'h5, 1, 0, 0, 0, 0);
        checkOutput("sc_memre", 32'(memre), 32'd0);
        checkOutput("sc_memwe", 32'(memwe), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("sc_rvld", 32'(eng_rvld), 32'd1);
        checkOutput("sc_rdd", eng_rdd, 32'h5);

        // CPU read of address 4 completes with grant+LAT+1 latency
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'd4, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("cr_memre", 32'(memre), 32'd1);
        checkOutput("cr_memra", 32'(memra), 32'd4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("cr_uprdy_early", 32'(uprdy), 32'd0);
        checkOutput("cr_no_rvld", 32'(eng_rvld), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("cr_uprdy", 32'(uprdy), 32'd1);
        checkOutput("cr_updo", updo, 32'h22);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("cr_uprdy_once", 32'(uprdy), 32'd0);

        // CPU read abandoned by dropping upen in WAIT_RD
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'd9, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ab_updo_low", updo, 32'd0);
        checkOutput("ab_uprdy", 32'(uprdy), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ab_uprdy_ret", 32'(uprdy), 32'd0);
        checkOutput("ab_rvld_ret", 32'(eng_rvld), 32'd0);
        checkOutput("ab_updo_ret", updo, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("ab_uprdy_idle", 32'(uprdy), 32'd0);
        checkOutput("ab_updo_kept", updo, 32'h22);

        // Reset with an engine read in flight
        applyStimulus(0, 1, 1, 0, 5'd2, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("rr_rvld_in_rst", 32'(eng_rvld), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkQuiet("rr_after");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
